// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the two-requester instruction ROM arbiter.
package rom_arb_pkg;

  // Default ROM byte-address width (covers 512 bytes, the ROM uses 176).
  localparam int ROM_AW = 9;

  // Owner encoding carried with each access through the response pipe.
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  // Tag travelling alongside a granted access for one cycle while the ROM reads.
  typedef struct packed {
    logic valid;
    logic owner;
    logic err;
  } s1_tag_t;

  // Flags misaligned addresses, addresses outside the ROM address window, and
  // addresses inside the window but beyond the populated depth.
  function automatic logic addr_err(input logic [31:0] addr, input int aw, input int depth);
    logic [31:0] hi;
    logic [31:0] lo;
    hi = addr >> aw;
    lo = addr & ((32'd1 << aw) - 32'd1);
    return (addr[1:0] != 2'b00) || (hi != 32'd0) || (lo >= 32'(depth));
  endfunction

endpackage

// File: rtl/rom_arb_pipe.sv
// Response pipe: holds the tag of the access the ROM is currently reading and
// steers the returned word into the owning port's response registers.
module rom_arb_pipe
  import rom_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  s1_tag_t       tag_in,
  input  logic          if_flush,
  input  logic [31:0]   rom_data,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  output logic          if_rerr,
  output logic          ls_rvalid,
  output logic [31:0]   ls_rdata,
  output logic          ls_rerr
);

  s1_tag_t     tag_p1;
  logic        if_take;
  logic        ls_take;
  logic [31:0] word_p1;

  // Stage p1: tag of the access whose ROM word arrives next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_p1 <= '0;
    end else begin
      tag_p1 <= tag_in;
    end
  end

  // Decide which port, if any, receives the word; a flush kills an IF-owned entry
  always_comb begin
    if_take = tag_p1.valid && (tag_p1.owner == OWN_IF) && !if_flush;
    ls_take = tag_p1.valid && (tag_p1.owner == OWN_LS);
    word_p1 = tag_p1.err ? 32'd0 : rom_data;
  end

  // Stage p2: IF response registers; data and error hold between responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid <= 1'b0;
      if_rdata  <= 32'd0;
      if_rerr   <= 1'b0;
    end else begin
      if_rvalid <= if_take;
      if (if_take) begin
        if_rdata <= word_p1;
        if_rerr  <= tag_p1.err;
      end
    end
  end

  // Stage p2: LS response registers; data and error hold between responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ls_rvalid <= 1'b0;
      ls_rdata  <= 32'd0;
      ls_rerr   <= 1'b0;
    end else begin
      ls_rvalid <= ls_take;
      if (ls_take) begin
        ls_rdata <= word_p1;
        ls_rerr  <= tag_p1.err;
      end
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares the single-port synchronous instruction ROM between instruction
// fetch (IF) and the load/store unit (LS). IF has fixed priority; LS is forced
// through after STARVE_LIMIT consecutive denied cycles. Responses come back
// in grant order with a fixed two-cycle latency.
module rom_arbiter #(
  parameter int ROM_AW       = rom_arb_pkg::ROM_AW,
  parameter int ROM_DEPTH    = 176,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_rerr,
  input  logic              ls_req,
  input  logic [31:0]       ls_addr,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              ls_rerr,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data
);

  import rom_arb_pkg::s1_tag_t;
  import rom_arb_pkg::OWN_IF;
  import rom_arb_pkg::OWN_LS;
  import rom_arb_pkg::addr_err;

  localparam int          SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  // Starvation count only ever climbs to LIMIT and then stays there.
  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == LIMIT) ? v : v + SW'(1);
  endfunction

  logic [SW-1:0] starve_cnt;
  logic          if_err;
  logic          ls_err;
  logic          if_eff;
  logic          ls_forced;
  s1_tag_t       tag_in;

  // Classify both request addresses every cycle, independent of who wins
  always_comb begin
    if_err = addr_err(if_addr, ROM_AW, ROM_DEPTH);
    ls_err = addr_err(ls_addr, ROM_AW, ROM_DEPTH);
  end

  // Grant: a flush takes IF out of contention, so LS wins that cycle if it asks
  always_comb begin
    if_eff    = if_req && !if_flush;
    ls_forced = (starve_cnt == LIMIT);
    ls_gnt    = rst_n && ls_req && (!if_eff || ls_forced);
    if_gnt    = rst_n && if_eff && !ls_gnt;
  end

  // ROM address from the winner; errored or idle cycles park the ROM at 0
  always_comb begin
    rom_addr = '0;
    if (ls_gnt) begin
      rom_addr = ls_err ? '0 : ls_addr[ROM_AW-1:0];
    end else if (if_gnt) begin
      rom_addr = if_err ? '0 : if_addr[ROM_AW-1:0];
    end
  end

  // Tag for the access entering the ROM read this cycle
  always_comb begin
    tag_in.valid = ls_gnt || if_gnt;
    tag_in.owner = ls_gnt ? OWN_LS : OWN_IF;
    tag_in.err   = ls_gnt ? ls_err : (if_gnt && if_err);
  end

  // Count consecutive denied LS cycles; any LS grant or idle LS cycle restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!ls_req || ls_gnt) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= sat_inc(starve_cnt);
    end
  end

  rom_arb_pipe u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .tag_in    (tag_in),
    .if_flush  (if_flush),
    .rom_data  (rom_data),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .if_rerr   (if_rerr),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .ls_rerr   (ls_rerr)
  );

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: table of arbitration vectors, hand-written corner
// sequences, and a randomized run against a transaction-level reference.
module tb_rom_arbiter;

  localparam int ROM_AW = 9;
  localparam int DEPTH  = 176;
  localparam int LIMIT  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              if_req = 1'b0;
  logic [31:0]       if_addr = 32'd0;
  logic              if_flush = 1'b0;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              if_rerr;
  logic              ls_req = 1'b0;
  logic [31:0]       ls_addr = 32'd0;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [31:0]       ls_rdata;
  logic              ls_rerr;
  logic [ROM_AW-1:0] rom_addr;
  logic [31:0]       rom_data;

  logic [31:0] mem [0:127];

  rom_arbiter #(.ROM_AW(ROM_AW), .ROM_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_rerr(if_rerr),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_rerr(ls_rerr),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: word available the cycle after the address is sampled
  always @(posedge clk) rom_data <= mem[rom_addr[8:2]];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference state: outstanding responses keyed by the cycle they must appear
  typedef struct {
    int          due;
    bit          owner;   // 0 = IF, 1 = LS
    logic [31:0] data;
    bit          err;
  } resp_t;
  resp_t q[$];
  int          starve = 0;
  logic [31:0] m_if_rdata = 32'd0, m_ls_rdata = 32'd0;
  logic        m_if_rerr = 1'b0, m_ls_rerr = 1'b0;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        fl;
    logic        lr;
    logic [31:0] la;
    logic        e_if_gnt;
    logic        e_ls_gnt;
    logic [8:0]  e_rom_addr;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= DEPTH);
  endfunction

  // One arbitration cycle: drive, check against the reference, advance the reference
  task automatic step(input logic ir, input logic [31:0] ia, input logic fl,
                      input logic lr, input logic [31:0] la);
    bit          e_if, e_ls, if_compete;
    logic [8:0]  e_ra;
    bit          v_if, v_ls;
    resp_t       nq[$];
    resp_t       r;
    @(negedge clk);
    rst_n = 1'b1;
    if_req = ir; if_addr = ia; if_flush = fl; ls_req = lr; ls_addr = la;
    #1;
    if_compete = ir && !fl;
    e_ls = lr && (!if_compete || starve == LIMIT);
    e_if = if_compete && !e_ls;
    e_ra = 9'd0;
    if (e_ls && !is_bad(la)) e_ra = la[8:0];
    if (e_if && !is_bad(ia)) e_ra = ia[8:0];
    v_if = 0; v_ls = 0;
    foreach (q[i]) begin
      if (q[i].due == cyc) begin
        if (q[i].owner) begin v_ls = 1; m_ls_rdata = q[i].data; m_ls_rerr = q[i].err; end
        else            begin v_if = 1; m_if_rdata = q[i].data; m_if_rerr = q[i].err; end
      end
    end
    chk("if_gnt", if_gnt, e_if);
    chk("ls_gnt", ls_gnt, e_ls);
    chk("rom_addr", rom_addr, e_ra);
    chk("if_rvalid", if_rvalid, v_if);
    chk("ls_rvalid", ls_rvalid, v_ls);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("if_rerr", if_rerr, m_if_rerr);
    chk("ls_rdata", ls_rdata, m_ls_rdata);
    chk("ls_rerr", ls_rerr, m_ls_rerr);
    foreach (q[i]) begin
      if (q[i].due != cyc && !(fl && !q[i].owner && q[i].due == cyc + 1))
        nq.push_back(q[i]);
    end
    q = nq;
    if (e_if || e_ls) begin
      r.due   = cyc + 2;
      r.owner = e_ls;
      r.err   = e_ls ? is_bad(la) : is_bad(ia);
      r.data  = r.err ? 32'd0 : mem[e_ls ? la[8:2] : ia[8:2]];
      q.push_back(r);
    end
    if (lr && !e_ls) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
    else             starve = 0;
    cyc++;
  endtask

  // Hold reset with requests active; everything must read as idle
  task automatic do_reset(input int n);
    q.delete();
    starve = 0;
    m_if_rdata = 32'd0; m_ls_rdata = 32'd0; m_if_rerr = 1'b0; m_ls_rerr = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      if_req = 1'b1; if_addr = 32'h4; if_flush = 1'b0; ls_req = 1'b1; ls_addr = 32'h14;
      #1;
      chk("rst_if_gnt", if_gnt, 1'b0);
      chk("rst_ls_gnt", ls_gnt, 1'b0);
      chk("rst_if_rvalid", if_rvalid, 1'b0);
      chk("rst_ls_rvalid", ls_rvalid, 1'b0);
      chk("rst_if_rerr", if_rerr, 1'b0);
      chk("rst_ls_rerr", ls_rerr, 1'b0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_ls_rdata", ls_rdata, 32'd0);
      chk("rst_rom_addr", rom_addr, 9'd0);
      cyc++;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0:       return ($urandom_range(0, 43) * 4) | $urandom_range(1, 3);
      1:       return $urandom_range(44, 127) * 4;
      2:       return 32'h1 << $urandom_range(9, 31);
      default: return $urandom_range(0, 43) * 4;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h5a000000 | (i * 32'h00010101);
    mem[0] = 32'h00010234;
    mem[1] = 32'h99000334;
    mem[5] = 32'hffff0124;

    //                ir   ia            fl   lr   la             eif  els  erom
    tbl[0]  = '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 9'h000};
    tbl[1]  = '{1'b1, 32'h0000_0004, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 9'h004};
    tbl[2]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'h14,        1'b0, 1'b1, 9'h014};
    tbl[3]  = '{1'b1, 32'h0000_0008, 1'b0, 1'b1, 32'h14,        1'b1, 1'b0, 9'h008};
    tbl[4]  = '{1'b1, 32'h0000_0008, 1'b0, 1'b1, 32'h14,        1'b1, 1'b0, 9'h008};
    tbl[5]  = '{1'b1, 32'h0000_0008, 1'b1, 1'b1, 32'h14,        1'b0, 1'b1, 9'h014};
    tbl[6]  = '{1'b1, 32'h0000_0006, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 9'h000};
    tbl[7]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'h200,       1'b0, 1'b1, 9'h000};
    tbl[8]  = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'hb0,        1'b0, 1'b1, 9'h000};
    tbl[9]  = '{1'b1, 32'h0000_00ac, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 9'h0ac};
    tbl[10] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 9'h000};
    tbl[11] = '{1'b1, 32'h0000_00ac, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 9'h000};
    tbl[12] = '{1'b1, 32'h0000_0010, 1'b0, 1'b1, 32'h80000000,  1'b1, 1'b0, 9'h010};
    tbl[13] = '{1'b1, 32'h0000_0004, 1'b1, 1'b1, 32'h1,         1'b0, 1'b1, 9'h000};

    // Reset held with requests active
    do_reset(3);

    // Arbitration vectors
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].ir, tbl[i].ia, tbl[i].fl, tbl[i].lr, tbl[i].la);
      chk("tbl_if_gnt", if_gnt, tbl[i].e_if_gnt);
      chk("tbl_ls_gnt", ls_gnt, tbl[i].e_ls_gnt);
      chk("tbl_rom_addr", rom_addr, tbl[i].e_rom_addr);
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // IF alone, back-to-back
    step(1, 32'h0, 0, 0, 0);
    step(1, 32'h4, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("if2_rvalid0", if_rvalid, 1'b1);
    chk("if2_rdata0", if_rdata, 32'h00010234);
    step(0, 0, 0, 0, 0);
    chk("if2_rvalid1", if_rvalid, 1'b1);
    chk("if2_rdata1", if_rdata, 32'h99000334);
    step(0, 0, 0, 0, 0);
    chk("if2_idle", if_rvalid, 1'b0);
    chk("if2_hold", if_rdata, 32'h99000334);

    // Contention: LS forced through every fifth cycle
    for (int i = 0; i < 20; i++) begin
      step(1, (i % 2) ? 32'h4 : 32'h0, 0, 1, 32'h14);
      chk("starve_ls_gnt", ls_gnt, (i % 5) == 4);
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("starve_ls_rdata", ls_rdata, 32'hffff0124);

    // Address errors on LS
    step(0, 0, 0, 1, 32'h6);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("err6_rvalid", ls_rvalid, 1'b1);
    chk("err6_rerr", ls_rerr, 1'b1);
    chk("err6_rdata", ls_rdata, 32'd0);
    step(0, 0, 0, 1, 32'h14);
    step(0, 0, 0, 1, 32'h200);
    step(0, 0, 0, 0, 0);
    chk("ok14_rerr", ls_rerr, 1'b0);
    step(0, 0, 0, 0, 0);
    chk("err200_rvalid", ls_rvalid, 1'b1);
    chk("err200_rerr", ls_rerr, 1'b1);
    chk("err200_rdata", ls_rdata, 32'd0);

    // Flush kills the in-flight fetch, LS traffic untouched
    step(0, 0, 0, 1, 32'h14);
    step(1, 32'h4, 0, 0, 0);
    step(1, 32'h0, 1, 1, 32'h14);
    chk("fl_ls_rvalid_a", ls_rvalid, 1'b1);
    step(0, 0, 0, 0, 0);
    chk("fl_if_killed", if_rvalid, 1'b0);
    step(0, 0, 0, 0, 0);
    chk("fl_ls_rvalid_b", ls_rvalid, 1'b1);
    chk("fl_ls_rdata", ls_rdata, 32'hffff0124);

    // Reset mid-operation
    step(1, 32'h0, 0, 1, 32'h14);
    step(1, 32'h4, 0, 1, 32'h14);
    step(1, 32'h0, 0, 1, 32'h14);
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h4, 0, 1, 32'h14);
      if (i < 2) begin
        chk("mid_rst_if_rvalid", if_rvalid, 1'b0);
        chk("mid_rst_ls_rvalid", ls_rvalid, 1'b0);
      end
      chk("mid_rst_ls_gnt", ls_gnt, i == 4);
    end

    // Randomized traffic against the reference
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset($urandom_range(1, 2));
      step($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 7) == 0,
           $urandom_range(0, 2) != 0, rand_addr());
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
